// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants and FSM state encoding for seq_alu.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_if
// Description : Request/response handshake bundle between a client and seq_alu.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_result;
    logic                 out_flag;
    logic                 out_err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out_result, out_flag, out_err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out_result, out_flag, out_err
    );
endinterface
`default_nettype wire

// File: rtl/cla_nbit.sv
`default_nettype none
// ============================================================================
// Module      : cla_nbit
// Description : WIDTH-bit adder built from 4-bit carry-lookahead groups.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NBLK = (WIDTH + 3) / 4;
    localparam int PW   = NBLK * 4;
    localparam int CB   = (WIDTH - 1) / 4;
    localparam int CO   = WIDTH - 4 * CB;

    logic [PW-1:0] w_p;
    logic [PW-1:0] w_g;
    logic [PW-1:0] w_sum;

    assign w_p = PW'(a) ^ PW'(b);
    assign w_g = PW'(a) & PW'(b);
    assign sum = w_sum[WIDTH-1:0];

    // Each group resolves all four carries from its own carry-in; groups chain.
    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        logic       w_ci;
        logic [3:0] w_pb;
        logic [3:0] w_gb;
        logic [4:0] w_cb;

        if (k == 0) begin : g_first
            assign w_ci = cin;
        end else begin : g_chain
            assign w_ci = g_blk[k-1].w_cb[4];
        end

        assign w_pb = w_p[4*k +: 4];
        assign w_gb = w_g[4*k +: 4];

        assign w_cb[0] = w_ci;
        assign w_cb[1] = w_gb[0] | (w_pb[0] & w_ci);
        assign w_cb[2] = w_gb[1] | (w_pb[1] & w_gb[0]) | (&w_pb[1:0] & w_ci);
        assign w_cb[3] = w_gb[2] | (w_pb[2] & w_gb[1]) | (&w_pb[2:1] & w_gb[0])
                       | (&w_pb[2:0] & w_ci);
        assign w_cb[4] = w_gb[3] | (w_pb[3] & w_gb[2]) | (&w_pb[3:2] & w_gb[1])
                       | (&w_pb[3:1] & w_gb[0]) | (&w_pb[3:0] & w_ci);

        assign w_sum[4*k +: 4] = w_pb ^ w_cb[3:0];

        if (k == CB) begin : g_cout
            assign cout = w_cb[CO];
        end
    end
endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Handshaked ALU; single-cycle ADD/SUB/logic, WIDTH-cycle shift-add MUL.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_alu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-2:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_flag;
    logic                 r_err;

    logic                 w_busy;
    logic [WIDTH-1:0]     w_add_a;
    logic [WIDTH-1:0]     w_add_b;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_cin;
    logic                 w_cout;
    logic [2*WIDTH-1:0]   w_prod;

    // The one adder serves the accepting edge in IDLE and every MUL step in BUSY.
    assign w_busy  = (r_state == BUSY);
    assign w_add_a = w_busy ? r_acc[2*WIDTH-2:WIDTH-1] : bus.a;
    assign w_add_b = w_busy ? (r_a[0] ? r_b : '0)
                            : ((bus.op == OP_SUB) ? ~bus.b : bus.b);
    assign w_cin   = !w_busy && (bus.op == OP_SUB);

    cla_nbit #(
        .WIDTH (WIDTH)
    ) u_cla (
        .a    (w_add_a),
        .b    (w_add_b),
        .cin  (w_cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Right-shifting accumulator: the retired low bit is always zero, so it is not stored.
    assign w_prod = {w_cout, w_sum, r_acc[WIDTH-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flag   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_state <= DONE;
                        r_flag  <= 1'b0;
                        r_err   <= 1'b0;
                        case (bus.op)
                            OP_ADD: begin
                                r_result <= {{WIDTH{1'b0}}, w_sum};
                                r_flag   <= w_cout;
                            end
                            OP_SUB: begin
                                r_result <= {{WIDTH{1'b0}}, w_sum};
                                r_flag   <= ~w_cout;
                            end
                            OP_MUL: begin
                                r_a     <= bus.a;
                                r_b     <= bus.b;
                                r_acc   <= '0;
                                r_cnt   <= '0;
                                r_state <= BUSY;
                            end
                            OP_AND: r_result <= {{WIDTH{1'b0}}, bus.a & bus.b};
                            OP_OR:  r_result <= {{WIDTH{1'b0}}, bus.a | bus.b};
                            OP_XOR: r_result <= {{WIDTH{1'b0}}, bus.a ^ bus.b};
                            default: begin
                                r_result <= '0;
                                r_err    <= 1'b1;
                            end
                        endcase
                    end
                end
                BUSY: begin
                    r_acc <= w_prod[2*WIDTH-1:1];
                    r_a   <= r_a >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_result <= w_prod;
                        r_flag   <= |w_prod[2*WIDTH-1:WIDTH];
                        r_err    <= 1'b0;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.out_valid  = (r_state == DONE);
    assign bus.out_result = r_result;
    assign bus.out_flag   = r_flag;
    assign bus.out_err    = r_err;
endmodule
`default_nettype wire
